// File: rtl/onchip_memory2_bist_master.sv
// onchip_memory2_bist_master: Avalon-MM fill/check BIST master.
// Writes a seeded address pattern over the whole RAM, reads it back and counts mismatches.
module onchip_memory2_bist_master #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    output logic [ADDR_W-1:0] address,
    output logic              chipselect,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic              clken,
    input  logic [DATA_W-1:0] readdata,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_err_addr
);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [2:0]        DRAIN_LAST = 3'(READ_LATENCY - 1);

    state_e                              state_q, state_d;
    logic [ADDR_W-1:0]                   addr_q, addr_d;
    logic [2:0]                          dcnt_q, dcnt_d;
    logic [DATA_W-1:0]                   seed_q, seed_d;
    logic                                go_q, go_d;
    logic [15:0]                         err_q, err_d;
    logic [ADDR_W-1:0]                   first_q, first_d;
    logic [READ_LATENCY-1:0]             vld_q, vld_d;
    logic [READ_LATENCY-1:0][ADDR_W-1:0] pa_q, pa_d;
    logic                                mismatch;
    logic                                bus_on;

    function automatic logic [DATA_W-1:0] pat(
        input logic [ADDR_W-1:0] a,
        input logic [DATA_W-1:0] s
    );
        logic [15:0] ax;
        ax = '0;
        ax[ADDR_W-1:0] = a;
        return ax[7:0] ^ ax[15:8] ^ s;
    endfunction

    // Read address rides alongside the slave latency so the compare sees its own address
    always_comb begin
        vld_d    = '0;
        pa_d     = '0;
        vld_d[0] = (state_q == READ);
        pa_d[0]  = addr_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            pa_d[i]  = pa_q[i-1];
        end
    end

    assign mismatch = vld_q[READ_LATENCY-1] &&
                      (readdata != pat(pa_q[READ_LATENCY-1], seed_q));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dcnt_d  = dcnt_q;
        seed_d  = seed_q;
        go_d    = 1'b0;
        err_d   = err_q;
        first_d = first_q;
        if (mismatch) begin
            if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
            if (err_q == 16'd0) first_d = pa_q[READ_LATENCY-1];
        end
        case (state_q)
            IDLE, DONE: begin
                if (go_q) begin
                    state_d = WRITE;
                    addr_d  = '0;
                end else if (start) begin
                    state_d = IDLE;
                    seed_d  = seed;
                    err_d   = '0;
                    first_d = '0;
                    go_d    = 1'b1;
                end
            end
            WRITE: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = READ;
            end
            READ: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 3'd1;
                if (dcnt_q == DRAIN_LAST) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            dcnt_q  <= '0;
            seed_q  <= '0;
            go_q    <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            vld_q   <= '0;
            pa_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dcnt_q  <= dcnt_d;
            seed_q  <= seed_d;
            go_q    <= go_d;
            err_q   <= err_d;
            first_q <= first_d;
            vld_q   <= vld_d;
            pa_q    <= pa_d;
        end
    end

    assign bus_on         = (state_q == WRITE) || (state_q == READ);
    assign chipselect     = bus_on;
    assign write          = (state_q == WRITE);
    assign address        = bus_on ? addr_q : '0;
    assign writedata      = write ? pat(addr_q, seed_q) : '0;
    assign busy           = bus_on || (state_q == DRAIN);
    assign clken          = busy;
    assign done           = (state_q == DONE);
    assign pass           = done && (err_q == 16'd0);
    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule
